// File: rtl/serial_exec_core.sv
// Bit-serial execute core: latches one operation, processes it LSB first over WIDTH
// cycles, then commits to a small register file. Define SERIAL_EXEC_SUB_EN to enable SUB (op 001).
module serial_exec_core #(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             carry,
  output logic [WIDTH-1:0] acc,
  input  logic [AW-1:0]    rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_LI   = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [AW-1:0]    r_rd;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_c;
  logic             r_ill;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_regs [NREGS];

  logic             w_accept;
  logic             w_last;
  logic             w_op_illegal;
  logic             w_carry_init;
  logic             w_arith;
  logic             w_b_bit;
  logic             w_sum;
  logic             w_cout;
  logic             w_bit;
  logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_EXEC_SUB_EN
  // SUB is rs1 + ~rs2 + 1: invert the rs2 bit stream and preset the carry.
  assign w_op_illegal = (op == OP_ILL);
  assign w_carry_init = (op == OP_SUB);
  assign w_arith      = (r_op == OP_ADD) || (r_op == OP_ADDI) || (r_op == OP_SUB);
  assign w_b_bit      = r_b[0] ^ (r_op == OP_SUB);
`else
  assign w_op_illegal = (op == OP_ILL) || (op == OP_SUB);
  assign w_carry_init = 1'b0;
  assign w_arith      = (r_op == OP_ADD) || (r_op == OP_ADDI);
  assign w_b_bit      = r_b[0];
`endif

  // DONE samples start like IDLE so back-to-back operations run every WIDTH+1 cycles.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  assign w_sum  = r_a[0] ^ w_b_bit ^ r_c;
  assign w_cout = (r_a[0] & w_b_bit) | (r_a[0] & r_c) | (w_b_bit & r_c);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_bit = w_sum;
    case (r_op)
      OP_AND:  w_bit = r_a[0] & r_b[0];
      OP_OR:   w_bit = r_a[0] | r_b[0];
      OP_XOR:  w_bit = r_a[0] ^ r_b[0];
      OP_LI:   w_bit = r_b[0];
      default: w_bit = w_sum;
    endcase
  end

  assign w_res_next = {w_bit, r_res};

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_ill   <= 1'b0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      // NOTE: the register file is small and must read zero after reset, so it is
      // reset explicitly; larger memories would normally be left unreset.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_EXEC: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next[WIDTH-1:1];
          r_c   <= w_cout;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            if (!r_ill) begin
              r_acc   <= w_res_next;
              r_carry <= w_arith ? w_cout : 1'b0;
              if (r_rd != '0) r_regs[r_rd] <= w_res_next;
            end
          end
        end
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state <= S_EXEC;
            r_cnt   <= '0;
            r_op    <= op;
            r_rd    <= rd;
            r_a     <= r_regs[rs1];
            r_b     <= ((op == OP_ADDI) || (op == OP_LI)) ? imm : r_regs[rs2];
            r_c     <= w_carry_init;
            r_ill   <= w_op_illegal;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == S_EXEC);
  assign done    = (r_state == S_DONE);
  assign illegal = done && r_ill;
  assign carry   = r_carry;
  assign acc     = r_acc;
  assign rd_data = (rd_sel == '0) ? '0 : r_regs[rd_sel];

endmodule

// File: tb/tb_serial_exec_core.sv
// Directed self-checking bench for serial_exec_core (WIDTH=8, NREGS=4); SUB vectors
// run when SERIAL_EXEC_SUB_EN is defined, otherwise op 001 is checked as illegal.
module tb_serial_exec_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [1:0] rd, rs1, rs2, rd_sel;
  logic [7:0] imm;
  logic       busy, done, illegal, carry;
  logic [7:0] acc, rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  serial_exec_core #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .busy(busy), .done(done), .illegal(illegal), .carry(carry), .acc(acc),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input logic [1:0] idx, input logic [7:0] exp, input string tag);
    rd_sel = idx;
    #1;
    check(tag, rd_data, exp);
  endtask

  // Issues one operation and returns at the done cycle, checking timing on the way.
  // scramble changes every input after acceptance and toggles start during EXEC.
  task automatic run_op(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [7:0] im, input bit exp_ill,
                        input bit scramble, input string tag);
    int busy_cnt;
    int lat;
    busy_cnt = 0;
    lat      = -1;
    @(negedge clk);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_busy_at_accept"}, busy, 1);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        if (scramble) begin
          op = 3'b111; rd = 2'd0; rs1 = 2'd0; rs2 = 2'd0; imm = ~im;
        end
      end
      if (scramble && n == 2) start = 1'b1;
      if (scramble && n == 3) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_busy_cycles"}, busy_cnt, 7);
    check({tag, "_illegal"}, illegal, exp_ill);
  endtask

  int t1, t2;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; rd_sel = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_carry", carry, 0);
    check("rst_acc", acc, 0);
    chk_reg(2'd1, 8'd0, "rst_r1");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b110, 2'd1, 2'd0, 2'd0, 8'd200, 1'b0, 1'b0, "li_r1");
    run_op(3'b110, 2'd2, 2'd0, 2'd0, 8'd100, 1'b0, 1'b0, "li_r2");
    run_op(3'b000, 2'd3, 2'd1, 2'd2, 8'd0,   1'b0, 1'b1, "add");
    check("add_acc", acc, 44);
    check("add_carry", carry, 1);
    chk_reg(2'd3, 8'd44, "add_r3");

    run_op(3'b111, 2'd3, 2'd1, 2'd2, 8'd5, 1'b1, 1'b0, "ill111");
    check("ill111_acc", acc, 44);
    check("ill111_carry", carry, 1);
    chk_reg(2'd3, 8'd44, "ill111_r3");

    run_op(3'b100, 2'd3, 2'd1, 2'd2, 8'd0, 1'b0, 1'b0, "xor");
    check("xor_acc", acc, 172);
    check("xor_carry", carry, 0);
    run_op(3'b010, 2'd3, 2'd1, 2'd2, 8'd0, 1'b0, 1'b0, "and");
    chk_reg(2'd3, 8'd64, "and_r3");
    run_op(3'b011, 2'd3, 2'd1, 2'd2, 8'd0, 1'b0, 1'b0, "or");
    chk_reg(2'd3, 8'd236, "or_r3");

    run_op(3'b110, 2'd1, 2'd0, 2'd0, 8'd9, 1'b0, 1'b0, "li9");
    run_op(3'b101, 2'd0, 2'd1, 2'd0, 8'd3, 1'b0, 1'b0, "addi_r0");
    check("addi_acc", acc, 12);
    check("addi_carry", carry, 0);
    chk_reg(2'd0, 8'd0, "addi_r0_zero");
    chk_reg(2'd1, 8'd9, "addi_r1_kept");

    run_op(3'b000, 2'd1, 2'd1, 2'd1, 8'd0, 1'b0, 1'b0, "add_self");
    chk_reg(2'd1, 8'd18, "add_self_r1");

`ifdef SERIAL_EXEC_SUB_EN
    run_op(3'b110, 2'd1, 2'd0, 2'd0, 8'd5, 1'b0, 1'b0, "li5");
    run_op(3'b110, 2'd2, 2'd0, 2'd0, 8'd7, 1'b0, 1'b0, "li7");
    run_op(3'b001, 2'd3, 2'd1, 2'd2, 8'd0, 1'b0, 1'b0, "sub_neg");
    chk_reg(2'd3, 8'd254, "sub_neg_r3");
    check("sub_neg_carry", carry, 0);
    run_op(3'b001, 2'd3, 2'd2, 2'd1, 8'd0, 1'b0, 1'b0, "sub_pos");
    chk_reg(2'd3, 8'd2, "sub_pos_r3");
    check("sub_pos_carry", carry, 1);
    run_op(3'b001, 2'd3, 2'd2, 2'd2, 8'd0, 1'b0, 1'b0, "sub_eq");
    check("sub_eq_acc", acc, 0);
    check("sub_eq_carry", carry, 1);
`else
    run_op(3'b001, 2'd3, 2'd1, 2'd2, 8'd0, 1'b1, 1'b0, "ill001");
    check("ill001_acc", acc, 18);
    chk_reg(2'd3, 8'd236, "ill001_r3");
`endif

    // Reset in the middle of EXEC aborts without writeback.
    @(negedge clk);
    op = 3'b000; rd = 2'd3; rs1 = 2'd1; rs2 = 2'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_acc", acc, 0);
    check("mid_rst_carry", carry, 0);
    chk_reg(2'd1, 8'd0, "mid_rst_r1");
    chk_reg(2'd3, 8'd0, "mid_rst_r3");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b110, 2'd1, 2'd0, 2'd0, 8'd17, 1'b0, 1'b0, "li17");
    chk_reg(2'd1, 8'd17, "li17_r1");

    // start held high: accepts every WIDTH+1 cycles.
    t1 = -1;
    t2 = -1;
    @(negedge clk);
    op = 3'b110; rd = 2'd2; imm = 8'd33; start = 1'b1;
    for (int c = 0; c < 40 && t2 < 0; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (t1 < 0) t1 = c;
        else        t2 = c;
      end
    end
    check("b2b_period", t2 - t1, 9);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_stop_busy", busy, 0);
    chk_reg(2'd2, 8'd33, "b2b_r2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
